// File: rtl/morphle_cfg_loader.sv
// Morphle Logic yblock configuration loader: Wishbone-fed row FIFO driving timed confclk strobes.
// Defining MORPHLE_CFG_READBACK_EN adds a FIFO that captures cbitout_i once per strobe.
module morphle_cfg_loader #(
    parameter int BLOCKWIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  morph_reset_o,
    output logic                  confclk_o,
    output logic [BLOCKWIDTH-1:0] cbitin_o,
    input  logic [BLOCKWIDTH-1:0] cbitout_i
);
    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     LVL_FULL   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]     LVL_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);
    localparam logic [15:0]     SETUP_LAST = 16'(SETUP_CYC - 1);
    localparam logic [15:0]     PULSE_LAST = 16'(PULSE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, HOLD} state_t;

    state_t                state, state_nxt;
    logic [15:0]           cnt, cnt_nxt;
    logic                  run, morph_reset;
    logic [15:0]           strobe_cnt;
    logic [BLOCKWIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           level;
    logic                  ovf;
    logic [1:0]            adr;
    logic                  valid, access, wr, rd, ctrl_wr, clr, push_req, push_ok, rb_rd;
    logic                  empty, full, abort, pop, strobe_inc, capture;
    logic                  rb_ovf;
    logic [31:0]           rb_word, status, rdata;
    logic                  unused;

    assign adr      = wbs_adr_i[3:2];
    assign valid    = wbs_cyc_i & wbs_stb_i;
    assign access   = valid & ~wbs_ack_o;
    assign wr       = access & wbs_we_i;
    assign rd       = access & ~wbs_we_i;
    assign ctrl_wr  = wr & (adr == 2'd0) & wbs_sel_i[0];
    assign clr      = ctrl_wr & wbs_dat_i[2];
    assign push_req = wr & (adr == 2'd2) & (|wbs_sel_i);
    assign rb_rd    = rd & (adr == 2'd3);

    // Abort takes effect on the same edge as the CTRL write, so confclk drops the following cycle.
    assign abort = clr | (ctrl_wr & wbs_dat_i[1]) | morph_reset;

    assign empty   = (level == '0);
    assign full    = (level == LVL_FULL);
    assign push_ok = push_req & (~full | pop);

    assign morph_reset_o = morph_reset;
    assign confclk_o     = (state == HIGH);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= valid & ~wbs_ack_o;
            if (access) begin
                wbs_dat_o <= wbs_we_i ? 32'h0 : rdata;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            run         <= 1'b0;
            morph_reset <= 1'b1;
        end else if (ctrl_wr) begin
            run         <= wbs_dat_i[0];
            morph_reset <= wbs_dat_i[1];
        end
    end

    always_comb begin
        status             = '0;
        status[0]          = (state != IDLE);
        status[1]          = empty;
        status[2]          = full;
        status[3]          = ovf;
        status[4]          = rb_ovf;
        status[8 +: AW+1]  = level;
        status[31:16]      = strobe_cnt;
    end

    always_comb begin
        rdata = '0;
        case (adr)
            2'd0:    rdata = {30'b0, morph_reset, run};
            2'd1:    rdata = status;
            2'd3:    rdata = rb_word;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (push_req && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok && !clr) begin
            mem[wr_ptr] <= wbs_dat_i[BLOCKWIDTH-1:0];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            cbitin_o <= '0;
        end else if (pop) begin
            cbitin_o <= mem[rd_ptr];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            strobe_cnt <= '0;
        end else if (clr) begin
            strobe_cnt <= '0;
        end else if (strobe_inc) begin
            strobe_cnt <= strobe_cnt + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pop        = 1'b0;
        strobe_inc = 1'b0;
        capture    = 1'b0;
        if (state != IDLE && abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run && !empty && !abort) begin
                        pop       = 1'b1;
                        state_nxt = SETUP;
                        cnt_nxt   = '0;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        capture   = 1'b1;
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
                HIGH: begin
                    if (cnt == PULSE_LAST) begin
                        strobe_inc = 1'b1;
                        state_nxt  = HOLD;
                        cnt_nxt    = '0;
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
                HOLD: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef MORPHLE_CFG_READBACK_EN
    logic [BLOCKWIDTH-1:0] rb_mem [FIFO_DEPTH];
    logic [AW-1:0]         rb_wr_ptr, rb_rd_ptr;
    logic [AW:0]           rb_level;
    logic                  rb_empty, rb_full, rb_pop, rb_push;

    assign rb_empty = (rb_level == '0);
    assign rb_full  = (rb_level == LVL_FULL);
    assign rb_pop   = rb_rd & ~rb_empty;
    assign rb_push  = capture & (~rb_full | rb_pop);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i || clr) begin
            rb_wr_ptr <= '0;
            rb_rd_ptr <= '0;
            rb_level  <= '0;
            rb_ovf    <= 1'b0;
        end else begin
            if (rb_push) begin
                rb_wr_ptr <= rb_wr_ptr + PTR_ONE;
            end
            if (rb_pop) begin
                rb_rd_ptr <= rb_rd_ptr + PTR_ONE;
            end
            case ({rb_push, rb_pop})
                2'b10:   rb_level <= rb_level + LVL_ONE;
                2'b01:   rb_level <= rb_level - LVL_ONE;
                default: rb_level <= rb_level;
            endcase
            if (capture && !rb_push) begin
                rb_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (rb_push) begin
            rb_mem[rb_wr_ptr] <= cbitout_i;
        end
    end

    always_comb begin
        rb_word = '0;
        if (!rb_empty) begin
            rb_word[BLOCKWIDTH-1:0] = rb_mem[rb_rd_ptr];
            rb_word[31]             = 1'b1;
        end
    end

    assign unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i};
`else
    assign rb_ovf  = 1'b0;
    assign rb_word = '0;
    assign unused  = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i, cbitout_i, capture, rb_rd};
`endif

endmodule

// File: tb/tb_morphle_cfg_loader.sv
// Directed bench for morphle_cfg_loader: bus registers, strobe timing, overflow, abort and clear.
module tb_morphle_cfg_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w, dat_r;
    logic        ack;
    logic        morph_reset, confclk;
    logic [15:0] cbitin, cbitout;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MORPHLE_CFG_READBACK_EN
    localparam logic [31:0] RBOVF = 32'h10;
`else
    localparam logic [31:0] RBOVF = 32'h0;
`endif

    always #5 clk = ~clk;

    morphle_cfg_loader dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .wbs_stb_i     (stb),
        .wbs_cyc_i     (cyc),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (dat_w),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (dat_r),
        .morph_reset_o (morph_reset),
        .confclk_o     (confclk),
        .cbitin_o      (cbitin),
        .cbitout_i     (cbitout)
    );

    // Strobe monitor: pulse count, captured row at each rising edge, pulse width, row stability.
    int          pulse_cnt = 0, len_bad = 0, stab_bad = 0, hi_len = 0, cyc_cnt = 0;
    logic        prev_cc = 1'b0;
    logic [15:0] prev_cbit = '0;
    logic [15:0] rows[$];
    int          rise_t[$];

    always @(negedge clk) begin
        cyc_cnt   <= cyc_cnt + 1;
        prev_cc   <= confclk;
        prev_cbit <= cbitin;
        if (confclk && !prev_cc) begin
            pulse_cnt <= pulse_cnt + 1;
            rows.push_back(cbitin);
            rise_t.push_back(cyc_cnt);
        end
        if (confclk) begin
            hi_len <= hi_len + 1;
        end else begin
            if (prev_cc && hi_len != 2) len_bad <= len_bad + 1;
            hi_len <= 0;
        end
        if ((confclk || prev_cc) && cbitin !== prev_cbit) stab_bad <= stab_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_cycle(input logic w, input logic [1:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] q);
        int n;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = {28'h0, a, 2'b00}; dat_w = d; sel = s;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        q = dat_r;
        if (!ack) check("wb_ack_timeout", {31'b0, ack}, 32'h1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_cycle(1'b1, a, d, 4'hF, q);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] q);
        wb_cycle(1'b0, a, 32'h0, 4'hF, q);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cc(input string tag);
        int n;
        n = 0;
        while (!confclk && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, {31'b0, confclk}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        int p0, r0;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; dat_w = '0; cbitout = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_morph_reset", {31'b0, morph_reset}, 32'h1);
        check("rst_confclk", {31'b0, confclk}, 32'h0);
        check("rst_cbitin", {16'b0, cbitin}, 32'h0);
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_dat", dat_r, 32'h0);
        rst_n = 1'b1;
        rd(2'd1, q); check("rst_status", q, 32'h0000_0002);
        rd(2'd0, q); check("rst_ctrl", q, 32'h0000_0002);

        // Two rows back to back
        p0 = pulse_cnt; r0 = rows.size();
        wr(2'd0, 32'h1);
        wr(2'd2, 32'hDEAD_A5A5);
        wr(2'd2, 32'h0000_0F0F);
        idle(20);
        check("two_pulses", pulse_cnt - p0, 32'd2);
        check("row_a5a5", {16'b0, rows[r0]}, 32'h0000_A5A5);
        check("row_0f0f", {16'b0, rows[r0+1]}, 32'h0000_0F0F);
        check("pulse_width", len_bad, 32'd0);
        check("row_stable", stab_bad, 32'd0);
        rd(2'd1, q); check("status_cnt2", q, 32'h0002_0002);
        check("cbitin_hold", {16'b0, cbitin}, 32'h0000_0F0F);

        // Overflow: nine pushes into eight entries with run off
        wr(2'd0, 32'h0);
        for (int i = 1; i <= 9; i++) wr(2'd2, 32'h1000 + i);
        rd(2'd1, q); check("status_full_ovf", q, 32'h0002_080C);
        p0 = pulse_cnt; r0 = rows.size();
        wr(2'd0, 32'h1);
        idle(60);
        check("eight_pulses", pulse_cnt - p0, 32'd8);
        for (int i = 0; i < 8; i++) check("ovf_row", {16'b0, rows[r0+i]}, 32'h1001 + i);
        check("throughput", rise_t[r0+7] - rise_t[r0], 32'd35);
        rd(2'd1, q); check("status_ovf_sticky", q, 32'h000A_000A | RBOVF);

        // morph_reset raised during HIGH
        wr(2'd0, 32'h0);
        for (int i = 1; i <= 3; i++) wr(2'd2, 32'h2000 + i);
        p0 = pulse_cnt; r0 = rows.size();
        wr(2'd0, 32'h1);
        wait_cc("abort_wait_high");
        wr(2'd0, 32'h3);
        check("abort_confclk_low", {31'b0, confclk}, 32'h0);
        check("abort_morph_reset", {31'b0, morph_reset}, 32'h1);
        rd(2'd1, q); check("status_after_abort", q, 32'h000A_0208 | RBOVF);
        idle(20);
        check("abort_no_more", pulse_cnt - p0, 32'd1);
        wr(2'd0, 32'h1);
        idle(30);
        check("resume_pulses", pulse_cnt - p0, 32'd3);
        check("resume_row0", {16'b0, rows[r0]}, 32'h0000_2001);
        check("resume_row1", {16'b0, rows[r0+1]}, 32'h0000_2002);
        check("resume_row2", {16'b0, rows[r0+2]}, 32'h0000_2003);
        rd(2'd1, q); check("status_resume", q, 32'h000C_000A | RBOVF);
        check("pulse_width_all", len_bad, 32'd0);
        check("row_stable_all", stab_bad, 32'd0);

        // clr while busy
        wr(2'd0, 32'h0);
        for (int i = 1; i <= 5; i++) wr(2'd2, 32'h3000 + i);
        p0 = pulse_cnt;
        wr(2'd0, 32'h1);
        wait_cc("clr_wait_high");
        wr(2'd0, 32'h5);
        check("clr_confclk_low", {31'b0, confclk}, 32'h0);
        rd(2'd1, q); check("status_after_clr", q, 32'h0000_0002);
        idle(40);
        check("clr_no_more", pulse_cnt - p0, 32'd1);
        rd(2'd0, q); check("ctrl_clr_reads0", q, 32'h0000_0001);

        // Byte-select and read-only paths
        wb_cycle(1'b1, 2'd0, 32'h2, 4'h0, q);
        rd(2'd0, q); check("ctrl_sel0_ignored", q, 32'h0000_0001);
        rd(2'd2, q); check("data_reads0", q, 32'h0);
        rd(2'd3, q); check("rback_empty0", q, 32'h0);

`ifdef MORPHLE_CFG_READBACK_EN
        wr(2'd0, 32'h0);
        wr(2'd2, 32'h5001);
        wr(2'd2, 32'h5002);
        cbitout = 16'h1234;
        wr(2'd0, 32'h1);
        wait_cc("rb_wait_high");
        cbitout = 16'hBEEF;
        idle(20);
        rd(2'd3, q); check("rback_1234", q, 32'h8000_1234);
        rd(2'd3, q); check("rback_beef", q, 32'h8000_BEEF);
        rd(2'd3, q); check("rback_drained", q, 32'h0);
`endif

        p0 = pulse_cnt; r0 = rows.size();
        wb_cycle(1'b1, 2'd2, 32'h0000_4444, 4'b1000, q);
        idle(15);
        check("sel3_push_pulse", pulse_cnt - p0, 32'd1);
        check("sel3_push_row", {16'b0, rows[r0]}, 32'h0000_4444);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
